// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard controller for a five-stage in-order pipeline. It
//            resolves load-use hazards with LOAD_LAT bubbles, freezes the
//            pipe during data-memory waits with a watchdog abort after
//            WAIT_MAX cycles, and flushes the younger stages on a taken
//            branch. It also keeps saturating stall and flush counters.
// Ports    : clk_i, rst_n                      clock, async active-low reset
//            idex_memread_i, idex_rt_addr_i    load in ID/EX and its target
//            ifid_rs_addr_i, ifid_rt_addr_i    sources of the IF/ID instr
//            branch_taken_i                    taken branch in EX/MEM
//            mem_req_i, mem_ready_i            data-memory handshake
//            clr_cnt_i                         clear counters and timeout
//            pc/ifid/idex/exmem_write_o        stage register load enables
//            ifid/idex/exmem_flush_o           stage control-field flushes
//            state_o                           RUN=0, LDSTALL=1, MWAIT=2
//            stall_cnt_o, flush_cnt_o          saturating perf counters
//            timeout_o                         sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int WAIT_MAX = 255
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_addr_i,
  input  logic [4:0]  ifid_rs_addr_i,
  input  logic [4:0]  ifid_rt_addr_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  input  logic        clr_cnt_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_write_o,
  output logic        exmem_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MWAIT   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [2:0]  BUB_INIT = 3'(LOAD_LAT - 1);
  localparam logic [7:0]  WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      state, state_nxt;
  logic [2:0]  bub_cnt, bub_nxt;
  logic [7:0]  wait_cnt, wait_nxt;

  logic        hz, mem_wait;
  logic        pc_w, ifid_w, idex_w, exmem_w;
  logic        ifid_fl, idex_fl, exmem_fl;
  logic        branch_evt, wd_evt;

  assign hz = idex_memread_i && (idex_rt_addr_i != 5'd0) &&
              ((idex_rt_addr_i == ifid_rs_addr_i) ||
               (idex_rt_addr_i == ifid_rt_addr_i));

  assign mem_wait = mem_req_i && !mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      bub_cnt  <= 3'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      bub_cnt  <= bub_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bub_nxt    = bub_cnt;
    wait_nxt   = wait_cnt;
    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    idex_w     = 1'b1;
    exmem_w    = 1'b1;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;
    exmem_fl   = 1'b0;
    branch_evt = 1'b0;
    wd_evt     = 1'b0;

    if (branch_taken_i) begin
      // A taken branch squashes everything younger, including any pending
      // load-use bubbles or an outstanding memory wait.
      ifid_fl    = 1'b1;
      idex_fl    = 1'b1;
      exmem_fl   = 1'b1;
      branch_evt = 1'b1;
      state_nxt  = RUN;
      bub_nxt    = 3'd0;
      wait_nxt   = 8'd0;
    end else begin
      case (state)
        RUN, LDSTALL: begin
          if (mem_wait) begin
            pc_w      = 1'b0;
            ifid_w    = 1'b0;
            idex_w    = 1'b0;
            exmem_w   = 1'b0;
            state_nxt = MWAIT;
            wait_nxt  = 8'd1;
            bub_nxt   = 3'd0;
          end else if (state == LDSTALL) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_fl = 1'b1;
            bub_nxt = bub_cnt - 3'd1;
            // This is the last bubble once the counter has run down to 1.
            if (bub_cnt <= 3'd1) begin
              state_nxt = RUN;
              bub_nxt   = 3'd0;
            end
          end else if (hz) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_fl = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LDSTALL;
              bub_nxt   = BUB_INIT;
            end
          end
        end
        MWAIT: begin
          if (mem_wait && (wait_cnt == WAIT_LIM)) begin
            // Watchdog: drop the stuck access and let the pipe move on.
            exmem_fl  = 1'b1;
            wd_evt    = 1'b1;
            state_nxt = RUN;
            wait_nxt  = 8'd0;
          end else if (mem_wait) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_w   = 1'b0;
            exmem_w  = 1'b0;
            wait_nxt = wait_cnt + 8'd1;
          end else begin
            state_nxt = RUN;
            wait_nxt  = 8'd0;
          end
        end
        default: begin
          state_nxt = RUN;
          bub_nxt   = 3'd0;
          wait_nxt  = 8'd0;
        end
      endcase
    end
  end

  // All controls are held low while reset is asserted.
  assign pc_write_o    = rst_n & pc_w;
  assign ifid_write_o  = rst_n & ifid_w;
  assign idex_write_o  = rst_n & idex_w;
  assign exmem_write_o = rst_n & exmem_w;
  assign ifid_flush_o  = rst_n & ifid_fl;
  assign idex_flush_o  = rst_n & idex_fl;
  assign exmem_flush_o = rst_n & exmem_fl;
  assign state_o       = state;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
      timeout_o   <= 1'b0;
    end else if (clr_cnt_i) begin
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
      timeout_o   <= 1'b0;
    end else begin
      if (!pc_w && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
      if (branch_evt && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + 16'd1;
      end
      if (wd_evt) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Two instances share
//            stimulus: inst 0 uses LOAD_LAT=1/WAIT_MAX=255, inst 1 uses
//            LOAD_LAT=3/WAIT_MAX=8. A count-based reference model predicts
//            every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       idex_memread;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       branch, mem_req, mem_ready, clr;

  logic        pc_a, ifw_a, idw_a, exw_a, ifl_a, idfl_a, exfl_a, tmo_a;
  logic [1:0]  st_a;
  logic [15:0] sc_a, fc_a;
  logic        pc_b, ifw_b, idw_b, exw_b, ifl_b, idfl_b, exfl_b, tmo_b;
  logic [1:0]  st_b;
  logic [15:0] sc_b, fc_b;

  pipe_hazard_ctrl #(.LOAD_LAT(1), .WAIT_MAX(255)) dut_a (
    .clk_i(clk), .rst_n(rst_n),
    .idex_memread_i(idex_memread), .idex_rt_addr_i(idex_rt),
    .ifid_rs_addr_i(ifid_rs), .ifid_rt_addr_i(ifid_rt),
    .branch_taken_i(branch), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .clr_cnt_i(clr),
    .pc_write_o(pc_a), .ifid_write_o(ifw_a), .idex_write_o(idw_a),
    .exmem_write_o(exw_a), .ifid_flush_o(ifl_a), .idex_flush_o(idfl_a),
    .exmem_flush_o(exfl_a), .state_o(st_a), .stall_cnt_o(sc_a),
    .flush_cnt_o(fc_a), .timeout_o(tmo_a)
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3), .WAIT_MAX(8)) dut_b (
    .clk_i(clk), .rst_n(rst_n),
    .idex_memread_i(idex_memread), .idex_rt_addr_i(idex_rt),
    .ifid_rs_addr_i(ifid_rs), .ifid_rt_addr_i(ifid_rt),
    .branch_taken_i(branch), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .clr_cnt_i(clr),
    .pc_write_o(pc_b), .ifid_write_o(ifw_b), .idex_write_o(idw_b),
    .exmem_write_o(exw_b), .ifid_flush_o(ifl_b), .idex_flush_o(idfl_b),
    .exmem_flush_o(exfl_b), .state_o(st_b), .stall_cnt_o(sc_b),
    .flush_cnt_o(fc_b), .timeout_o(tmo_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining bubbles, wait length and event counts.
  int lat[2]  = '{1, 3};
  int wmax[2] = '{255, 8};
  int bub[2], waited[2], stall[2], flush[2];
  bit waiting[2], tmo[2];

  // Packed view: {pc,ifid,idex,exmem write, ifid,idex,exmem flush,
  //               state[1:0], stall[15:0], flush[15:0], timeout}
  logic [41:0] exp_v[2], obs_v[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      bub[k] = 0; waited[k] = 0; stall[k] = 0; flush[k] = 0;
      waiting[k] = 0; tmo[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k);
    bit hz, mw, t0;
    bit [6:0] ctl;
    int st, s0, f0;
    st = waiting[k] ? 2 : ((bub[k] > 0) ? 1 : 0);
    s0 = stall[k]; f0 = flush[k]; t0 = tmo[k];
    hz = idex_memread && (idex_rt != 0) &&
         ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    mw = mem_req && !mem_ready;
    ctl = 7'b1111_000;
    if (branch) begin
      ctl = 7'b1111_111;
      if (flush[k] < 65535) flush[k]++;
      bub[k] = 0; waiting[k] = 0;
    end else if (waiting[k]) begin
      if (mw && waited[k] == wmax[k]) begin
        ctl = 7'b1111_001; tmo[k] = 1; waiting[k] = 0;
      end else if (mw) begin
        ctl = 7'b0000_000; waited[k]++;
      end else begin
        waiting[k] = 0;
      end
    end else if (mw) begin
      ctl = 7'b0000_000; waiting[k] = 1; waited[k] = 1; bub[k] = 0;
    end else if (bub[k] > 0) begin
      ctl = 7'b0011_010; bub[k]--;
    end else if (hz) begin
      ctl = 7'b0011_010; bub[k] = lat[k] - 1;
    end
    if (!ctl[6] && stall[k] < 65535) stall[k]++;
    if (clr) begin
      stall[k] = 0; flush[k] = 0; tmo[k] = 0;
    end
    exp_v[k] = {ctl, 2'(st), 16'(s0), 16'(f0), t0};
  endfunction

  function automatic void capture();
    obs_v[0] = {pc_a, ifw_a, idw_a, exw_a, ifl_a, idfl_a, exfl_a, st_a, sc_a, fc_a, tmo_a};
    obs_v[1] = {pc_b, ifw_b, idw_b, exw_b, ifl_b, idfl_b, exfl_b, st_b, sc_b, fc_b, tmo_b};
  endfunction

  // One clock: sample and predict at the falling edge, then move past the
  // rising edge so the caller can drive the next inputs.
  task automatic tick();
    @(negedge clk);
    model_step(0);
    model_step(1);
    capture();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    branch = 0; mem_req = 0; mem_ready = 0; clr = 0;
  endtask

  task automatic clear_counters();
    idle_inputs();
    clr = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_v[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL clr inst%0d got %h want %h", k, obs_v[k], exp_v[k]);
      end
    end
    clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    branch = 1; idex_memread = 1; idex_rt = 5; ifid_rs = 5;
    rst_n = 0;
    model_reset();
    #1;
    @(posedge clk); #1;
    capture();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_v[k] !== 42'd0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d got %h want 0", k, obs_v[k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_load_use();
    int st_want[4] = '{0, 1, 1, 0};
    clear_counters();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin idex_memread = 1; idex_rt = 5; ifid_rs = 5; ifid_rt = 9; end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL load_use c%0d inst%0d got %h want %h", c, k, obs_v[k], exp_v[k]);
        end
      end
      n_checks++;
      if (obs_v[1][34:33] !== 2'(st_want[c])) begin
        n_fail++;
        $display("FAIL load_use_state c%0d got %0d want %0d", c, obs_v[1][34:33], st_want[c]);
      end
    end
    n_checks++;
    if (sc_a !== 16'd1 || sc_b !== 16'd3) begin
      n_fail++;
      $display("FAIL load_use_stalls got %0d/%0d want 1/3", sc_a, sc_b);
    end
  endtask

  task automatic test_r0();
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
      tick();
      n_checks++;
      if (obs_v[0][41] !== 1'b1 || obs_v[1][41] !== 1'b1 ||
          obs_v[0] !== exp_v[0] || obs_v[1] !== exp_v[1]) begin
        n_fail++;
        $display("FAIL r0_no_stall c%0d got %h/%h want %h/%h", c, obs_v[0], obs_v[1], exp_v[0], exp_v[1]);
      end
    end
  endtask

  task automatic test_branch_hazard();
    clear_counters();
    idle_inputs();
    branch = 1; idex_memread = 1; idex_rt = 7; ifid_rt = 7;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_v[k][41:35] !== 7'b1111111 || obs_v[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL branch_hz inst%0d got %h want %h", k, obs_v[k], exp_v[k]);
      end
    end
    idle_inputs();
    n_checks++;
    if (fc_a !== 16'd1 || fc_b !== 16'd1 || sc_a !== 16'd0 || sc_b !== 16'd0) begin
      n_fail++;
      $display("FAIL branch_counts got f%0d/%0d s%0d/%0d want f1/1 s0/0", fc_a, fc_b, sc_a, sc_b);
    end
  endtask

  task automatic test_mem_wait();
    int st_want[6] = '{0, 2, 2, 2, 2, 0};
    clear_counters();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      mem_req = (c < 5); mem_ready = (c == 4);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v[k] !== exp_v[k] || obs_v[k][34:33] !== 2'(st_want[c]) ||
            obs_v[k][41:38] !== ((c < 4) ? 4'b0000 : 4'b1111)) begin
          n_fail++;
          $display("FAIL mem_wait c%0d inst%0d got %h want %h", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    n_checks++;
    if (sc_a !== 16'd4 || sc_b !== 16'd4) begin
      n_fail++;
      $display("FAIL mem_wait_stalls got %0d/%0d want 4/4", sc_a, sc_b);
    end
  endtask

  task automatic test_watchdog();
    clear_counters();
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      mem_req = (c < 9); mem_ready = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL watchdog c%0d inst%0d got %h want %h", c, k, obs_v[k], exp_v[k]);
        end
      end
      // Instance with WAIT_MAX=8: eight frozen cycles, then the abort pulse.
      n_checks++;
      if (obs_v[1][35] !== (c == 8) || obs_v[1][41] !== (c >= 8)) begin
        n_fail++;
        $display("FAIL watchdog_pulse c%0d got exfl=%0b pc=%0b", c, obs_v[1][35], obs_v[1][41]);
      end
    end
    n_checks++;
    if (tmo_b !== 1'b1 || tmo_a !== 1'b0 || sc_b !== 16'd8) begin
      n_fail++;
      $display("FAIL timeout_flag got %0b/%0b stalls %0d want 0/1 stalls 8", tmo_a, tmo_b, sc_b);
    end
    clear_counters();
    n_checks++;
    if (tmo_b !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear got %0b want 0", tmo_b);
    end
  endtask

  task automatic test_reset_abort();
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    tick();
    tick();
    rst_n = 0;
    model_reset();
    #1;
    capture();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_v[k] !== 42'd0) begin
        n_fail++;
        $display("FAIL reset_abort inst%0d got %h want 0", k, obs_v[k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
    idex_memread = 1; idex_rt = 3; ifid_rs = 3;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_v[k] !== exp_v[k] || obs_v[k][34:33] !== 2'd0) begin
        n_fail++;
        $display("FAIL after_reset inst%0d got %h want %h", k, obs_v[k], exp_v[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      idex_memread = ($urandom_range(0, 9) < 4);
      idex_rt      = 5'($urandom_range(0, 7));
      ifid_rs      = 5'($urandom_range(0, 7));
      ifid_rt      = 5'($urandom_range(0, 7));
      branch       = ($urandom_range(0, 9) == 0);
      mem_req      = ($urandom_range(0, 9) < 3);
      mem_ready    = ($urandom_range(0, 9) < 5);
      clr          = ($urandom_range(0, 99) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_v[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d got %h want %h", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_load_use();
    test_r0();
    test_branch_hazard();
    test_mem_wait();
    test_watchdog();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
